except_issue: RTL

Pipeline-side issuer of exception and CP0-access requests for the dual-issue core. It collects per-slot exception flags, PCs and operands from the memory stage and tracks branch delay slots across slots and cycles. It enforces precise-exception ordering between the two slots and emits one registered, encoded 16-bit request word per slot to the coprocessor-0 unit. After a flush it squashes wrong-path requests for a fixed window.

---
 rtl/except_issue_if.sv | 29 ++
 rtl/except_issue.sv | 100 ++++++++++
 2 files changed

// File: rtl/except_issue_if.sv
// except_issue_if: memory-stage request inputs and encoded CP0 request outputs for except_issue.
interface except_issue_if;
  logic        stall;
  logic        valid1, valid2;
  logic [31:0] pc1, pc2;
  logic        br1, br2;
  logic [6:0]  exc1, exc2;
  logic [2:0]  op1, op2;
  logic [4:0]  cp0_addr1, cp0_addr2;
  logic [31:0] rt1, rt2;
  logic [31:0] badaddr1, badaddr2;
  logic [15:0] excepttype_o1, excepttype_o2;
  logic [31:0] current_pc_o1, current_pc_o2;
  logic [31:0] rt_rdata_o1, rt_rdata_o2;
  logic [31:0] bad_addr_o1, bad_addr_o2;
  logic        flush_o, squash_o;
  modport master (
    output stall, valid1, valid2, pc1, pc2, br1, br2, exc1, exc2, op1, op2,
           cp0_addr1, cp0_addr2, rt1, rt2, badaddr1, badaddr2,
    input  excepttype_o1, excepttype_o2, current_pc_o1, current_pc_o2,
           rt_rdata_o1, rt_rdata_o2, bad_addr_o1, bad_addr_o2, flush_o, squash_o
  );
  modport slave (
    input  stall, valid1, valid2, pc1, pc2, br1, br2, exc1, exc2, op1, op2,
           cp0_addr1, cp0_addr2, rt1, rt2, badaddr1, badaddr2,
    output excepttype_o1, excepttype_o2, current_pc_o1, current_pc_o2,
           rt_rdata_o1, rt_rdata_o2, bad_addr_o1, bad_addr_o2, flush_o, squash_o
  );
endinterface

// File: rtl/except_issue.sv
// except_issue: encodes per-slot exception/CP0 requests with precise slot ordering,
// delay-slot tracking and a post-flush squash window.
module except_issue #(
  parameter int SQUASH_CYCLES = 2
) (
  input logic          clk,
  input logic          rst,
  except_issue_if.slave bus
);
  localparam int CW = $clog2(SQUASH_CYCLES + 1);

  typedef enum logic {RUN, SQUASH} state_t;

  typedef struct packed {
    logic [15:0] et1, et2;
    logic [31:0] pc1, pc2, rt1, rt2, ba1, ba2;
    logic        flush;
  } out_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ds_pend_q, ds_pend_d;
  out_t          out_q, out_d;
  logic          accept, kill, live2;
  logic [15:0]   w1, w2;

  // Exception field uses the same bit order as the input, one-hot by priority.
  function automatic logic [6:0] exc_pick(input logic [6:0] e);
    return e[6] ? 7'h40 : e[0] ? 7'h01 : e[2] ? 7'h04 : e[1] ? 7'h02 :
           e[3] ? 7'h08 : e[4] ? 7'h10 : e[5] ? 7'h20 : 7'h00;
  endfunction

  function automatic logic [2:0] op_pick(input logic [2:0] o);
    return o[2] ? 3'b100 : o[0] ? 3'b001 : o[1] ? 3'b010 : 3'b000;
  endfunction

  function automatic logic [15:0] encode(input logic v, input logic [6:0] e,
                                         input logic [2:0] o, input logic [4:0] a,
                                         input logic ds);
    logic [6:0] x;
    x = exc_pick(e);
    return v ? {a, ds, x, (|x) ? 3'b000 : op_pick(o)} : 16'h0000;
  endfunction

  always_comb begin
    accept = (state_q == RUN) && !bus.stall && !out_q.flush;
    w1     = encode(bus.valid1, bus.exc1, bus.op1, bus.cp0_addr1, ds_pend_q);
    kill   = |w1[9:2];
    live2  = bus.valid2 && !kill;
    w2     = live2 ? encode(1'b1, bus.exc2, bus.op2, bus.cp0_addr2, bus.valid1 & bus.br1) : 16'h0000;
    out_d       = '0;
    out_d.et1   = accept ? w1 : 16'h0000;
    out_d.et2   = accept ? w2 : 16'h0000;
    out_d.pc1   = (accept && bus.valid1) ? bus.pc1 : 32'h0;
    out_d.rt1   = (accept && bus.valid1) ? bus.rt1 : 32'h0;
    out_d.ba1   = (accept && bus.valid1) ? bus.badaddr1 : 32'h0;
    out_d.pc2   = (accept && live2) ? bus.pc2 : 32'h0;
    out_d.rt2   = (accept && live2) ? bus.rt2 : 32'h0;
    out_d.ba2   = (accept && live2) ? bus.badaddr2 : 32'h0;
    out_d.flush = accept && (kill || (|w2[9:2]));
    ds_pend_d = !accept ? ds_pend_q :
                (live2 && bus.br2) ? 1'b1 :
                bus.valid1 ? 1'b0 : ds_pend_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == RUN && out_q.flush) begin
      state_d   = SQUASH;
      cnt_d     = CW'(SQUASH_CYCLES);
      ds_pend_d = 1'b0;
    end else if (state_q == SQUASH) begin
      cnt_d   = cnt_q - CW'(1);
      state_d = (cnt_q == CW'(1)) ? RUN : SQUASH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      ds_pend_q <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ds_pend_q <= ds_pend_d;
      out_q     <= out_d;
    end
  end

  assign bus.excepttype_o1 = out_q.et1;
  assign bus.excepttype_o2 = out_q.et2;
  assign bus.current_pc_o1 = out_q.pc1;
  assign bus.current_pc_o2 = out_q.pc2;
  assign bus.rt_rdata_o1   = out_q.rt1;
  assign bus.rt_rdata_o2   = out_q.rt2;
  assign bus.bad_addr_o1   = out_q.ba1;
  assign bus.bad_addr_o2   = out_q.ba2;
  assign bus.flush_o       = out_q.flush;
  assign bus.squash_o      = (state_q == SQUASH);
endmodule
